// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for 8 requesters: rotating descending priority, registered one-hot grant,
// done/req-drop release and hold watchdog. Request sampled in cycle t -> grant visible t+1.
module rr_arb8_ctrl #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         EN,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [2:0]   gnt_id,
    output logic         valid,
    output logic         timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [N-1:0]     r_gnt;
    logic [2:0]       r_gnt_id;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [2:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic [N-1:0]     w_gnt_nxt;
    logic [2:0]       w_gnt_id_nxt;
    logic             w_timeout_nxt;

    logic             w_found;
    logic [2:0]       w_win;
    logic [2:0]       w_idx;
    logic             w_release;
    logic             w_expired;

    // Search starts at ptr and walks downward, wrapping 0 -> 7.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_idx   = 3'd0;
        for (int k = 0; k < N; k++) begin
            w_idx = r_ptr - 3'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_release = !EN || done || !req[r_gnt_id];
    assign w_expired = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gnt_nxt      = r_gnt;
        w_gnt_id_nxt   = r_gnt_id;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (EN && w_found) begin
                    w_state_nxt    = S_GRANT;
                    w_gnt_nxt      = N'(1) << w_win;
                    w_gnt_id_nxt   = w_win;
                    w_hold_cnt_nxt = '0;
                    w_ptr_nxt      = w_win - 3'd1;
                end else begin
                    w_gnt_nxt    = '0;
                    w_gnt_id_nxt = 3'd0;
                end
            end
            S_GRANT: begin
                if (w_release || w_expired) begin
                    w_state_nxt   = S_IDLE;
                    w_gnt_nxt     = '0;
                    w_gnt_id_nxt  = 3'd0;
                    // Watchdog only reports when no ordinary release fired the same cycle.
                    w_timeout_nxt = !w_release;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 3'd7;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_id   <= 3'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign valid   = |r_gnt;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Directed bench for rr_arb8_ctrl with MAX_HOLD=4; outputs sampled 1ns after each rising edge.
module tb_rr_arb8_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       EN;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       valid;
    logic       timeout;

    int n_total = 0;
    int n_bad   = 0;

    rr_arb8_ctrl #(.N(8), .MAX_HOLD(4), .CNT_W(5)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .EN      (EN),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                              input logic e_to);
        chk({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
        chk({tag, ".gnt_id"},  32'(gnt_id),  32'(e_id));
        chk({tag, ".valid"},   32'(valid),   32'(e_gnt != 8'h00));
        chk({tag, ".timeout"}, 32'(timeout), 32'(e_to));
    endtask

    // One grant of the expected id, released by done one cycle later, then the IDLE gap.
    task automatic grant_cycle(input string tag, input logic [2:0] e_id);
        logic [7:0] one;
        one  = 8'h01;
        done = 1'b0;
        tick();
        expect_out({tag, ".g"}, one << e_id, e_id, 1'b0);
        done = 1'b1;
        tick();
        expect_out({tag, ".idle"}, 8'h00, 3'd0, 1'b0);
        done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        expect_out("rst", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        EN   = 1'b1;
        req  = 8'hFF;
        done = 1'b0;

        // T1 reset
        tick();
        expect_out("t1.rst0", 8'h00, 3'd0, 1'b0);
        tick();
        expect_out("t1.rst1", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("t1.first", 8'h80, 3'd7, 1'b0);
        done = 1'b1;
        req  = 8'hA0;
        tick();
        expect_out("t1.rel", 8'h00, 3'd0, 1'b0);
        done = 1'b0;

        // T2 rotation between 7 and 5 (ptr now 6)
        grant_cycle("t2.a", 3'd5);
        grant_cycle("t2.b", 3'd7);
        grant_cycle("t2.c", 3'd5);
        grant_cycle("t2.d", 3'd7);

        // T3 fairness over all eight
        req = 8'hFF;
        do_reset();
        for (int i = 7; i >= 0; i--) grant_cycle("t3", 3'(i));
        grant_cycle("t3.wrap", 3'd7);

        // T4 watchdog
        req = 8'h01;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("t4.hold", 8'h01, 3'd0, 1'b0);
        end
        tick();
        expect_out("t4.expire", 8'h00, 3'd0, 1'b1);
        tick();
        expect_out("t4.regrant", 8'h01, 3'd0, 1'b0);
        done = 1'b1;
        tick();
        expect_out("t4.rel", 8'h00, 3'd0, 1'b0);
        done = 1'b0;

        // T5 holder drops req (ptr 7 -> winner 3)
        req = 8'h0C;
        tick();
        expect_out("t5.g3", 8'h08, 3'd3, 1'b0);
        tick();
        expect_out("t5.g3b", 8'h08, 3'd3, 1'b0);
        req = 8'h04;
        tick();
        expect_out("t5.drop", 8'h00, 3'd0, 1'b0);
        tick();
        expect_out("t5.g2", 8'h04, 3'd2, 1'b0);
        EN  = 1'b0;
        req = 8'hFF;
        tick();
        expect_out("t5.en_off", 8'h00, 3'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("t5.en_low", 8'h00, 3'd0, 1'b0);
        end
        EN = 1'b1;
        grant_cycle("t5.resume", 3'd1);

        // T6 done coincides with the last allowed hold cycle (ptr 0)
        req = 8'h01;
        tick();
        expect_out("t6.c0", 8'h01, 3'd0, 1'b0);
        tick();
        expect_out("t6.c1", 8'h01, 3'd0, 1'b0);
        tick();
        expect_out("t6.c2", 8'h01, 3'd0, 1'b0);
        tick();
        expect_out("t6.c3", 8'h01, 3'd0, 1'b0);
        done = 1'b1;
        tick();
        expect_out("t6.done_last", 8'h00, 3'd0, 1'b0);
        done = 1'b0;

        // T6 reset mid-grant restores ptr=7 (without it the winner would be 2)
        req = 8'h08;
        tick();
        expect_out("t6.g3", 8'h08, 3'd3, 1'b0);
        rst = 1'b1;
        req = 8'hFF;
        tick();
        expect_out("t6.rst", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("t6.after_rst", 8'h80, 3'd7, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
